hdma: RTL and testbench

// - CGB VRAM DMA engine (FF51-FF55). Copies 16-byte blocks from the CPU bus into VRAM;

---
 rtl/hdma_if.sv | 33 +++
 rtl/hdma.sv | 183 ++++++++++++++++++
 tb/tb_hdma.sv | 398 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/hdma_if.sv
// hdma_if: CPU register window, source read bus and VRAM write port
// of the CGB HDMA engine. master = DMA engine, slave = system side.
interface hdma_if;
  logic        cpu_sel_reg;
  logic [7:0]  cpu_addr;
  logic        cpu_wr;
  logic [7:0]  cpu_di;
  logic [7:0]  cpu_do;
  logic [15:0] src_addr;
  logic        src_rd;
  logic [7:0]  src_data;
  logic [12:0] vram_addr;
  logic [7:0]  vram_di;
  logic        vram_wren;
  logic        vram1_wren;
  logic        cpu_stall;

  modport master (
    input  cpu_sel_reg, cpu_addr, cpu_wr, cpu_di,
    input  src_data,
    output cpu_do, src_addr, src_rd,
    output vram_addr, vram_di, vram_wren, vram1_wren,
    output cpu_stall
  );

  modport slave (
    output cpu_sel_reg, cpu_addr, cpu_wr, cpu_di,
    output src_data,
    input  cpu_do, src_addr, src_rd,
    input  vram_addr, vram_di, vram_wren, vram1_wren,
    input  cpu_stall
  );
endinterface

// File: rtl/hdma.sv
// hdma: CGB VRAM DMA (FF51-FF55), GDMA bursts and HBlank-paced HDMA.
// Option `HDMA_LCDOFF_XFER_EN: HDMA blocks also run while the LCD is off.
module hdma #(
  parameter int BLK_BYTES = 16
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ce,
  input  logic       isGBC,
  input  logic       vbk,
  input  logic [1:0] lcd_mode,
  input  logic       lcd_on,
  hdma_if.master     bus
);

  localparam int BW =
    (BLK_BYTES > 1) ? $clog2(BLK_BYTES) : 1;
  localparam logic [BW-1:0] LAST = BW'(BLK_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE, GDMA_XFER, HDMA_WAIT, HDMA_XFER, HDMA_HOLD
  } st_t;

  st_t           st_q, st_n;
  logic          ph_q, ph_n;
  logic [BW-1:0] bc_q, bc_n;
  logic [15:0]   src_q, src_n;
  logic [12:0]   dst_q, dst_n;
  logic [6:0]    rem_q, rem_n;
  logic          stop_q, stop_n;
  logic          bank_q, bank_n;
  logic [1:0]    mode_q;

  logic       wr, wr55, hb_edge, go, leave;
  logic       xfer, wr_ph;
  logic [7:0] di;
  logic [13:0] dst_sum;

  assign di      = bus.cpu_di;
  assign wr      = ce & bus.cpu_wr & bus.cpu_sel_reg & isGBC;
  assign wr55    = wr & (bus.cpu_addr == 8'h55);
  assign hb_edge = lcd_on & (lcd_mode == 2'b00)
                 & (mode_q != 2'b00);
  assign dst_sum = {1'b0, dst_q} + 14'd1;

`ifdef HDMA_LCDOFF_XFER_EN
  assign go    = hb_edge | ~lcd_on;
  assign leave = (lcd_mode != 2'b00) | ~lcd_on;
`else
  assign go    = hb_edge;
  assign leave = (lcd_mode != 2'b00);
`endif

  assign xfer  = isGBC & ((st_q == GDMA_XFER)
               | (st_q == HDMA_XFER));
  assign wr_ph = xfer & ph_q;

  always_comb begin
    st_n   = st_q;
    ph_n   = ph_q;
    bc_n   = bc_q;
    src_n  = src_q;
    dst_n  = dst_q;
    rem_n  = rem_q;
    stop_n = stop_q;
    bank_n = bank_q;
    unique case (st_q)
      IDLE: begin
        ph_n   = 1'b0;
        bc_n   = '0;
        stop_n = 1'b0;
        if (wr) begin
          unique case (1'b1)
            bus.cpu_addr == 8'h51: src_n[15:8] = di;
            bus.cpu_addr == 8'h52: src_n[7:0] = {di[7:4], 4'h0};
            bus.cpu_addr == 8'h53: dst_n[12:8] = di[4:0];
            bus.cpu_addr == 8'h54: dst_n[7:0] = {di[7:4], 4'h0};
            bus.cpu_addr == 8'h55: begin
              rem_n  = di[6:0];
              bank_n = vbk;
              st_n   = di[7] ? HDMA_WAIT : GDMA_XFER;
            end
            default: ;
          endcase
        end
      end
      GDMA_XFER, HDMA_XFER: begin
        ph_n = ~ph_q;
        if (ph_q) begin
          src_n = src_q + 16'd1;
          dst_n = dst_sum[12:0];
          bc_n  = bc_q + BW'(1);
          if (dst_sum[13]) begin
            // running off the top of VRAM ends the whole transfer
            st_n  = IDLE;
            rem_n = 7'h7F;
          end else if (bc_q == LAST) begin
            bc_n  = '0;
            rem_n = rem_q - 7'd1;
            if (rem_q == 7'd0) stop_n = 1'b1;
            if (st_q == HDMA_XFER) st_n = HDMA_HOLD;
            else if (rem_q == 7'd0) st_n = IDLE;
          end
        end
        if (st_q == HDMA_XFER && wr55) begin
          if (di[7]) begin
            rem_n  = di[6:0];
            stop_n = 1'b0;
          end else begin
            stop_n = 1'b1;
          end
        end
      end
      HDMA_WAIT: begin
        ph_n = 1'b0;
        bc_n = '0;
        if (wr55) begin
          if (di[7]) rem_n = di[6:0];
          else st_n = IDLE;
        end else if (go) begin
          st_n   = HDMA_XFER;
          bank_n = vbk;
        end
      end
      HDMA_HOLD: begin
        if (wr55) begin
          if (di[7]) begin
            rem_n  = di[6:0];
            stop_n = 1'b0;
          end else begin
            st_n = IDLE;
          end
        end else if (stop_q) begin
          st_n = IDLE;
        end else if (leave) begin
          st_n = HDMA_WAIT;
        end
      end
      default: st_n = IDLE;
    endcase
    if (!isGBC) begin
      st_n = IDLE;
      ph_n = 1'b0;
      bc_n = '0;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      st_q   <= IDLE;
      ph_q   <= 1'b0;
      bc_q   <= '0;
      src_q  <= 16'h0000;
      dst_q  <= 13'h0000;
      rem_q  <= 7'h7F;
      stop_q <= 1'b0;
      bank_q <= 1'b0;
      mode_q <= 2'b00;
    end else if (ce) begin
      st_q   <= st_n;
      ph_q   <= ph_n;
      bc_q   <= bc_n;
      src_q  <= src_n;
      dst_q  <= dst_n;
      rem_q  <= rem_n;
      stop_q <= stop_n;
      bank_q <= bank_n;
      mode_q <= lcd_mode;
    end
  end

  assign bus.cpu_do =
    (isGBC & bus.cpu_sel_reg & (bus.cpu_addr == 8'h55))
    ? {st_q == IDLE, rem_q} : 8'hFF;
  assign bus.src_addr   = src_q;
  assign bus.src_rd     = xfer & ~ph_q & ce;
  assign bus.vram_addr  = dst_q;
  assign bus.vram_di    = wr_ph ? bus.src_data : 8'h00;
  assign bus.vram_wren  = wr_ph & ce & ~bank_q;
  assign bus.vram1_wren = wr_ph & ce & bank_q;
  assign bus.cpu_stall  = xfer;

endmodule

// File: tb/tb_hdma.sv
// tb_hdma: randomized bench for hdma against a block-level copy model
// (expected VRAM write stream, FF55 readback, stall ce count).
module tb_hdma;
  localparam int BLK = 16;

  logic       clk_sys = 1'b0;
  logic       reset_n;
  logic       ce = 1'b1;
  logic       isGBC = 1'b1;
  logic       vbk = 1'b0;
  logic [1:0] lcd_mode = 2'b10;
  logic       lcd_on = 1'b1;
  bit         rnd_ce = 1'b0;

  hdma_if bus();

  hdma #(.BLK_BYTES(BLK)) dut (
    .clk_sys (clk_sys),
    .reset_n (reset_n),
    .ce      (ce),
    .isGBC   (isGBC),
    .vbk     (vbk),
    .lcd_mode(lcd_mode),
    .lcd_on  (lcd_on),
    .bus     (bus)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic        bank;
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  logic [7:0] smem [65536];
  wr_t exp_q[$];
  int  m_src, m_dst, m_rem;
  bit  m_act, m_bank, m_cancel;
  int  n_chk = 0, n_fail = 0;
  int  wr_cnt = 0, wr1_cnt = 0, stall_cnt = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // source memory answers one ce tick after the read strobe
  always @(posedge clk_sys)
    if (ce && bus.src_rd) bus.src_data <= smem[bus.src_addr];

  always @(negedge clk_sys) begin
    if (ce && bus.cpu_stall) stall_cnt <= stall_cnt + 1;
    if (ce && (bus.vram_wren || bus.vram1_wren)) begin
      wr_cnt <= wr_cnt + 1;
      if (bus.vram1_wren) wr1_cnt <= wr1_cnt + 1;
      chk("wr_both", 32'(bus.vram_wren & bus.vram1_wren), 0);
      if (exp_q.size() == 0) begin
        chk("extra_wr", 32'(bus.vram_addr), 32'hFFFF_FFFF);
      end else begin
        chk("wr_addr", 32'(bus.vram_addr), 32'(exp_q[0].addr));
        chk("wr_data", 32'(bus.vram_di), 32'(exp_q[0].data));
        chk("wr_bank", 32'(bus.vram1_wren), 32'(exp_q[0].bank));
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic model_block(output bit ovf);
    ovf = 1'b0;
    for (int i = 0; i < BLK; i++) begin
      exp_q.push_back('{bank: m_bank, addr: 13'(m_dst),
                        data: smem[m_src]});
      m_src = (m_src + 1) & 16'hFFFF;
      m_dst++;
      if (m_dst > 8191) begin
        ovf = 1'b1;
        break;
      end
    end
  endtask

  task automatic model_gdma(logic [7:0] v, output int nb);
    int q0, nblk;
    bit ovf;
    q0 = exp_q.size();
    nblk = int'(v[6:0]) + 1;
    m_bank = vbk;
    for (int b = 0; b < nblk; b++) begin
      model_block(ovf);
      if (ovf) break;
    end
    m_act = 1'b0;
    m_rem = 127;
    nb = exp_q.size() - q0;
  endtask

  task automatic model_hblank(output int nb);
    int q0;
    bit ovf;
    nb = 0;
    if (m_act) begin
      q0 = exp_q.size();
      m_bank = vbk;
      model_block(ovf);
      nb = exp_q.size() - q0;
      if (ovf || m_rem == 0) begin
        m_act = 1'b0;
        m_rem = 127;
      end else begin
        m_rem--;
        if (m_cancel) m_act = 1'b0;
      end
    end
    m_cancel = 1'b0;
  endtask

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
      if (rnd_ce) ce = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic wr_reg(logic [7:0] a, logic [7:0] v);
    ce = 1'b1;
    bus.cpu_sel_reg = 1'b1;
    bus.cpu_addr = a;
    bus.cpu_di = v;
    bus.cpu_wr = 1'b1;
    tick();
    bus.cpu_wr = 1'b0;
    bus.cpu_sel_reg = 1'b0;
  endtask

  task automatic rd_reg(logic [7:0] a, output logic [7:0] v);
    bus.cpu_sel_reg = 1'b1;
    bus.cpu_addr = a;
    #2;
    v = bus.cpu_do;
    bus.cpu_sel_reg = 1'b0;
  endtask

  task automatic chk55(string tag);
    logic [7:0] v;
    rd_reg(8'h55, v);
    chk(tag, 32'(v), 32'({~m_act, 7'(m_rem)}));
  endtask

  task automatic set_addr(logic [15:0] s, logic [15:0] d);
    wr_reg(8'h51, s[15:8]);
    wr_reg(8'h52, s[7:0]);
    wr_reg(8'h53, d[15:8]);
    wr_reg(8'h54, d[7:0]);
    m_src = int'(s) & 16'hFFF0;
    m_dst = int'(d) & 16'h1FF0;
  endtask

  task automatic wait_done(string tag, int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.cpu_stall) && n < budget) begin
      tick();
      n++;
    end
    chk({tag, "_drain"}, 32'(exp_q.size()), 0);
    chk({tag, "_stall_end"}, 32'(bus.cpu_stall), 0);
    tick(4);
  endtask

  task automatic do_gdma(logic [7:0] v, string tag);
    int s0, w0, nb;
    s0 = stall_cnt;
    w0 = wr_cnt;
    model_gdma(v, nb);
    wr_reg(8'h55, v);
    wait_done(tag, 6000);
    chk({tag, "_wr"}, 32'(wr_cnt - w0), 32'(nb));
    chk({tag, "_stall"}, 32'(stall_cnt - s0), 32'(2 * nb));
    chk55({tag, "_ff55"});
  endtask

  task automatic hblank(string tag, bit mid_mode, bit mid_cancel);
    int w0, nb;
    w0 = wr_cnt;
    if (mid_cancel) m_cancel = 1'b1;
    model_hblank(nb);
    lcd_mode = 2'b00;
    tick(3);
    if (mid_mode) lcd_mode = 2'b11;
    if (mid_cancel) wr_reg(8'h55, 8'h00);
    tick(2 * BLK + 6);
    wait_done(tag, 300);
    lcd_mode = 2'b10;
    tick(3);
    chk({tag, "_wr"}, 32'(wr_cnt - w0), 32'(nb));
  endtask

  initial begin
    logic [7:0] v;
    int w0, s0, nb;
    bit found;

    for (int i = 0; i < 65536; i++) smem[i] = 8'($urandom);
    bus.cpu_sel_reg = 1'b0;
    bus.cpu_addr = 8'h00;
    bus.cpu_wr = 1'b0;
    bus.cpu_di = 8'h00;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    tick(3);
    m_src = 0; m_dst = 0; m_rem = 127;
    m_act = 1'b0; m_cancel = 1'b0; m_bank = 1'b0;

    chk("rst_src_rd", 32'(bus.src_rd), 0);
    chk("rst_wren", 32'(bus.vram_wren), 0);
    chk("rst_wren1", 32'(bus.vram1_wren), 0);
    chk("rst_stall", 32'(bus.cpu_stall), 0);
    chk("rst_vaddr", 32'(bus.vram_addr), 0);
    chk("rst_saddr", 32'(bus.src_addr), 0);
    chk("rst_vdi", 32'(bus.vram_di), 0);
    chk("rst_cpu_do", 32'(bus.cpu_do), 32'hFF);
    chk55("rst_ff55");
    reset_n = 1'b1;
    tick(2);
    rd_reg(8'h51, v);
    chk("rd_ff51", 32'(v), 32'hFF);

    set_addr(16'hC000, 16'h8000);
    do_gdma(8'h01, "gdma_c0");

    set_addr(16'hFFE0, 16'h0400);
    do_gdma(8'h02, "gdma_wrap");

    rnd_ce = 1'b1;
    for (int i = 0; i < 6; i++) begin
      set_addr(16'($urandom), 16'($urandom));
      do_gdma(8'($urandom_range(0, 3)), "gdma_rnd");
    end
    rnd_ce = 1'b0;
    ce = 1'b1;

    set_addr(16'($urandom), 16'h1FF0);
    do_gdma(8'h01, "dst_ovf");

    vbk = 1'b1;
    s0 = wr1_cnt;
    set_addr(16'($urandom), 16'h0200);
    do_gdma(8'h00, "bank1");
    chk("bank1_cnt", 32'(wr1_cnt - s0), 32'(BLK));
    vbk = 1'b0;

    lcd_on = 1'b1;
    lcd_mode = 2'b10;
    set_addr(16'($urandom), 16'h9000);
    wr_reg(8'h55, 8'h82);
    m_act = 1'b1; m_rem = 2;
    chk55("hd_arm");
    hblank("hd1", 1'b0, 1'b0);
    chk55("hd1_ff55");
    hblank("hd2", 1'b1, 1'b0);
    chk55("hd2_ff55");
    hblank("hd3", 1'b0, 1'b0);
    chk55("hd3_ff55");

    set_addr(16'($urandom), 16'h0800);
    lcd_mode = 2'b00;
    tick(2);
    w0 = wr_cnt;
    wr_reg(8'h55, 8'h80);
    m_act = 1'b1; m_rem = 0;
    tick(2 * BLK + 20);
    chk("hb_inprog_wr", 32'(wr_cnt - w0), 0);
    lcd_mode = 2'b10;
    tick(2);
    hblank("hb_next", 1'b0, 1'b0);
    chk55("hb_next_ff55");

    set_addr(16'($urandom), 16'h0A00);
    wr_reg(8'h55, 8'h87);
    m_act = 1'b1; m_rem = 7;
    hblank("cn1", 1'b0, 1'b0);
    hblank("cn2", 1'b0, 1'b0);
    chk55("cn_act_ff55");
    wr_reg(8'h55, 8'h00);
    m_act = 1'b0;
    chk55("cn_ff55");
    hblank("cn_after", 1'b0, 1'b0);
    chk55("cn_after_ff55");

    set_addr(16'($urandom), 16'h0C00);
    wr_reg(8'h55, 8'h83);
    m_act = 1'b1; m_rem = 3;
    hblank("cmid", 1'b0, 1'b1);
    chk55("cmid_ff55");
    hblank("cmid_after", 1'b0, 1'b0);

    set_addr(16'($urandom), 16'h0E00);
    wr_reg(8'h55, 8'h81);
    m_act = 1'b1; m_rem = 1;
    hblank("rs1", 1'b0, 1'b0);
    chk55("rs1_ff55");
    wr_reg(8'h55, 8'h83);
    m_rem = 3;
    chk55("rs_reload");
    hblank("rs2", 1'b0, 1'b0);
    chk55("rs2_ff55");
    wr_reg(8'h55, 8'h00);
    m_act = 1'b0;
    chk55("rs_cancel");

    set_addr(16'($urandom), 16'h1000);
    w0 = wr_cnt;
    model_gdma(8'h01, nb);
    wr_reg(8'h55, 8'h01);
    found = 1'b0;
    for (int k = 0; k < 300 && !found; k++) begin
      tick();
      if (bus.vram_wren && (wr_cnt - w0) == 4) found = 1'b1;
    end
    chk("rst_reach", 32'(found), 1);
    reset_n = 1'b0;
    #1;
    chk("rst_mid_wren", 32'(bus.vram_wren), 0);
    chk("rst_mid_wren1", 32'(bus.vram1_wren), 0);
    chk("rst_mid_rd", 32'(bus.src_rd), 0);
    chk("rst_mid_stall", 32'(bus.cpu_stall), 0);
    chk("rst_mid_vaddr", 32'(bus.vram_addr), 0);
    exp_q.delete();
    m_act = 1'b0; m_rem = 127;
    chk55("rst_mid_ff55");
    tick(2);
    reset_n = 1'b1;
    m_src = 0; m_dst = 0;
    tick(3);
    chk("rst_mid_nwr", 32'(wr_cnt - w0), 4);

    isGBC = 1'b0;
    rd_reg(8'h55, v);
    chk("nogbc_rd", 32'(v), 32'hFF);
    w0 = wr_cnt;
    s0 = stall_cnt;
    wr_reg(8'h55, 8'h00);
    tick(80);
    chk("nogbc_wr", 32'(wr_cnt - w0), 0);
    chk("nogbc_stall", 32'(stall_cnt - s0), 0);
    isGBC = 1'b1;
    tick(2);
    chk55("nogbc_ff55");

    set_addr(16'($urandom), 16'h1400);
    model_gdma(8'h03, nb);
    wr_reg(8'h55, 8'h03);
    tick(7);
    isGBC = 1'b0;
    #1;
    chk("gbc_off_stall", 32'(bus.cpu_stall), 0);
    chk("gbc_off_wren", 32'(bus.vram_wren), 0);
    w0 = wr_cnt;
    tick(100);
    chk("gbc_off_nwr", 32'(wr_cnt - w0), 0);
    exp_q.delete();
    isGBC = 1'b1;
    tick(2);

    set_addr(16'($urandom), 16'h1600);
    lcd_on = 1'b0;
    lcd_mode = 2'b00;
    tick(2);
    w0 = wr_cnt;
    m_act = 1'b1; m_rem = 0;
`ifdef HDMA_LCDOFF_XFER_EN
    model_hblank(nb);
`else
    nb = 0;
`endif
    wr_reg(8'h55, 8'h80);
    tick(2 * BLK + 10);
    wait_done("lcdoff", 300);
    chk("lcdoff_wr", 32'(wr_cnt - w0), 32'(nb));
    chk55("lcdoff_ff55");
`ifndef HDMA_LCDOFF_XFER_EN
    wr_reg(8'h55, 8'h00);
    m_act = 1'b0;
    chk55("lcdoff_cancel");
`endif
    lcd_on = 1'b1;
    lcd_mode = 2'b10;
    tick(4);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
